// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//                owner_e tags who owns an in-flight read, pri_e is the
//                priority state of the arbiter, plus default bus widths.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

   localparam int c_DEF_ADDR_W  = 9;
   localparam int c_DEF_DATA_W  = 32;
   localparam int c_STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_CORE = 2'd1,
      OWNER_DMA  = 2'd2
   } owner_e;

   typedef enum logic {
      CORE_PRI = 1'b0,
      DMA_PRI  = 1'b1
   } pri_e;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_starve_ctr
//  Description : Counts consecutive cycles in which the DMA requests but is
//                not granted. Clears on a grant or when the request drops,
//                saturates at the limit. hit_next flags that the counter's
//                next value equals the limit, so the priority FSM can switch
//                on the same edge the counter reaches it.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-low reset
//                req      - DMA request
//                gnt      - DMA grant this cycle
//                limit    - saturation / switch threshold
//                hit_next - next counter value equals limit
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_starve_ctr #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             gnt,
   input  logic [CNT_W-1:0] limit,
   output logic             hit_next
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;

   always_comb begin
      w_cnt_next = '0;
      if (req && !gnt) begin
         if (r_cnt >= limit) begin
            w_cnt_next = limit;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

   assign hit_next = (w_cnt_next == limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

endmodule : dmem_starve_ctr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one synchronous-read data-memory port between the
//                core MEM stage and a DMA/debug loader. The core wins
//                conflicts by default; after STARVE_LIMIT consecutive denied
//                DMA cycles the DMA wins exactly one conflict. Read data is
//                returned the cycle after the access to whoever issued it.
//  Ports       : clk, reset (async, active-low)
//                core_rd/core_wr/core_addr/core_wr_data - core request
//                core_stall, core_rvalid, core_rd_data   - core response
//                dma_req/dma_we/dma_addr/dma_wr_data     - DMA request
//                dma_gnt, dma_rvalid, dma_rd_data        - DMA response
//                mem_rd/mem_wr/mem_addr/mem_wr_data      - memory command
//                mem_rd_data                             - memory read data
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
   parameter int          DATA_W       = 32,
   parameter int          ADDR_W       = 9,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   // core side
   input  logic              core_rd,
   input  logic              core_wr,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rd_data,
   // DMA side
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wr_data,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rd_data,
   // memory side
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   import dmem_arb_pkg::*;

   localparam logic [c_STARVE_CNT_W-1:0] c_STARVE_LIMIT = c_STARVE_CNT_W'(STARVE_LIMIT);

   pri_e   r_pri;
   pri_e   w_pri_next;
   owner_e r_ret_owner;
   owner_e w_ret_owner_next;

   logic w_core_req;
   logic w_core_granted;
   logic w_dma_granted;
   logic w_starve_hit_next;

   // ------------------------------------------------------------------------
   // Grant. The DMA takes the port when it is alone, or on a conflict while
   // in DMA_PRI. Everything is masked while reset is held so all outputs
   // read 0 regardless of the requesters.
   // ------------------------------------------------------------------------
   always_comb begin
      w_core_req     = core_rd | core_wr;
      w_dma_granted  = reset & dma_req & (~w_core_req | (r_pri == DMA_PRI));
      w_core_granted = reset & w_core_req & ~w_dma_granted;
   end

   assign core_stall = reset & w_core_req & ~w_core_granted;
   assign dma_gnt    = w_dma_granted;

   // ------------------------------------------------------------------------
   // Memory command mux. A core access with both rd and wr set is a write;
   // the read strobe is suppressed so no return is ever generated for it.
   // ------------------------------------------------------------------------
   always_comb begin
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (w_core_granted) begin
         mem_wr      = core_wr;
         mem_rd      = core_rd & ~core_wr;
         mem_addr    = core_addr;
         mem_wr_data = core_wr_data;
      end else if (w_dma_granted) begin
         mem_wr      = dma_we;
         mem_rd      = ~dma_we;
         mem_addr    = dma_addr;
         mem_wr_data = dma_wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Starvation counter
   // ------------------------------------------------------------------------
   dmem_starve_ctr #(
      .CNT_W (c_STARVE_CNT_W)
   ) u_starve_ctr (
      .clk      (clk),
      .reset    (reset),
      .req      (dma_req),
      .gnt      (w_dma_granted),
      .limit    (c_STARVE_LIMIT),
      .hit_next (w_starve_hit_next)
   );

   // ------------------------------------------------------------------------
   // Priority FSM. DMA_PRI holds for a single DMA grant (or until the DMA
   // gives up), then the core regains default priority.
   // ------------------------------------------------------------------------
   always_comb begin
      w_pri_next = r_pri;
      case (r_pri)
         CORE_PRI: begin
            if (w_starve_hit_next) begin
               w_pri_next = DMA_PRI;
            end
         end
         DMA_PRI: begin
            if (w_dma_granted || !dma_req) begin
               w_pri_next = CORE_PRI;
            end
         end
         default: w_pri_next = CORE_PRI;
      endcase
   end

   // Owner of the read issued this cycle; returned data is routed to it next
   // cycle. Only one access per cycle, so a single tag covers full-rate reads.
   always_comb begin
      w_ret_owner_next = OWNER_NONE;
      if (mem_rd) begin
         w_ret_owner_next = w_core_granted ? OWNER_CORE : OWNER_DMA;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pri       <= CORE_PRI;
         r_ret_owner <= OWNER_NONE;
      end else begin
         r_pri       <= w_pri_next;
         r_ret_owner <= w_ret_owner_next;
      end
   end

   // ------------------------------------------------------------------------
   // Read return routing; the non-owner sees zero data.
   // ------------------------------------------------------------------------
   always_comb begin
      core_rvalid  = 1'b0;
      dma_rvalid   = 1'b0;
      core_rd_data = '0;
      dma_rd_data  = '0;
      if (reset) begin
         if (r_ret_owner == OWNER_CORE) begin
            core_rvalid  = 1'b1;
            core_rd_data = mem_rd_data;
         end else if (r_ret_owner == OWNER_DMA) begin
            dma_rvalid  = 1'b1;
            dma_rd_data = mem_rd_data;
         end
      end
   end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. A reference model
//                tracks the DMA's denied-cycle streak and a shadow memory;
//                per-cycle expectations go into queues and a negedge monitor
//                compares the DUT against them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 9;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              core_rd, core_wr;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wr_data;
   logic              core_stall, core_rvalid;
   logic [DATA_W-1:0] core_rd_data;
   logic              dma_req, dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wr_data;
   logic              dma_gnt, dma_rvalid;
   logic [DATA_W-1:0] dma_rd_data;
   logic              mem_rd, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset_n),
      .core_rd      (core_rd),
      .core_wr      (core_wr),
      .core_addr    (core_addr),
      .core_wr_data (core_wr_data),
      .core_stall   (core_stall),
      .core_rvalid  (core_rvalid),
      .core_rd_data (core_rd_data),
      .dma_req      (dma_req),
      .dma_we       (dma_we),
      .dma_addr     (dma_addr),
      .dma_wr_data  (dma_wr_data),
      .dma_gnt      (dma_gnt),
      .dma_rvalid   (dma_rvalid),
      .dma_rd_data  (dma_rd_data),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_rd_data  (mem_rd_data)
   );

   // Environment memory driven by the DUT's memory port (synchronous read).
   logic [DATA_W-1:0] env_mem [512];
   always @(posedge clk) begin
      if (mem_wr) env_mem[mem_addr] <= mem_wr_data;
      if (mem_rd) mem_rd_data <= env_mem[mem_addr];
   end

   // ---------------- reference model state ----------------
   typedef struct {
      logic              stall, gnt, mrd, mwr, chk_wd, crv, drv;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
   } rec_t;

   rec_t              cyc_q[$];
   logic [DATA_W-1:0] exp_core_q[$];
   logic [DATA_W-1:0] exp_dma_q[$];
   logic [DATA_W-1:0] ref_mem [512];
   int                streak;     // consecutive denied DMA request cycles
   int                pend;       // 0 none, 1 core read, 2 DMA read in flight
   int                n_tests = 0;
   int                n_fail  = 0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, record what the spec says must happen.
   task automatic cyc(input logic crd, input logic cwr, input logic [ADDR_W-1:0] ca,
                      input logic [DATA_W-1:0] cd, input logic dr, input logic dwe,
                      input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
      rec_t r;
      logic creq, dwin, cwin;
      core_rd = crd; core_wr = cwr; core_addr = ca; core_wr_data = cd;
      dma_req = dr;  dma_we = dwe;  dma_addr = da;  dma_wr_data = dd;
      r = '{default: '0};
      if (!reset_n) begin
         streak = 0;
         pend   = 0;
         exp_core_q.delete();
         exp_dma_q.delete();
         r.chk_wd = 1'b1;
      end else begin
         creq = crd | cwr;
         dwin = dr && (!creq || streak == STARVE_LIMIT);
         cwin = creq && !dwin;
         r.stall = creq && !cwin;
         r.gnt   = dwin;
         r.crv   = (pend == 1);
         r.drv   = (pend == 2);
         r.chk_wd = 1'b1;
         if (cwin) begin
            r.mwr = cwr; r.mrd = !cwr; r.addr = ca; r.wd = cd;
         end else if (dwin) begin
            r.mwr = dwe; r.mrd = !dwe; r.addr = da; r.wd = dd;
         end
         if (r.mrd) r.chk_wd = 1'b0;     // write data is don't-care on reads
         pend = 0;
         if (r.mrd) begin
            if (cwin) begin exp_core_q.push_back(ref_mem[r.addr]); pend = 1; end
            else      begin exp_dma_q.push_back(ref_mem[r.addr]);  pend = 2; end
         end
         if (r.mwr) ref_mem[r.addr] = r.wd;
         streak = (dr && !dwin) ? streak + 1 : 0;
      end
      cyc_q.push_back(r);
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin : mon
      rec_t r;
      logic [DATA_W-1:0] e;
      if (cyc_q.size() > 0) begin
         r = cyc_q.pop_front();
         chk("core_stall",  {31'b0, core_stall},  {31'b0, r.stall});
         chk("dma_gnt",     {31'b0, dma_gnt},     {31'b0, r.gnt});
         chk("mem_rd",      {31'b0, mem_rd},      {31'b0, r.mrd});
         chk("mem_wr",      {31'b0, mem_wr},      {31'b0, r.mwr});
         chk("mem_addr",    {23'b0, mem_addr},    {23'b0, r.addr});
         if (r.chk_wd) chk("mem_wr_data", mem_wr_data, r.wd);
         chk("core_rvalid", {31'b0, core_rvalid}, {31'b0, r.crv});
         chk("dma_rvalid",  {31'b0, dma_rvalid},  {31'b0, r.drv});
         if (r.crv) begin
            e = (exp_core_q.size() > 0) ? exp_core_q.pop_front() : 32'hxxxxxxxx;
            chk("core_rd_data", core_rd_data, e);
         end else begin
            chk("core_rd_data_idle", core_rd_data, '0);
         end
         if (r.drv) begin
            e = (exp_dma_q.size() > 0) ? exp_dma_q.pop_front() : 32'hxxxxxxxx;
            chk("dma_rd_data", dma_rd_data, e);
         end else begin
            chk("dma_rd_data_idle", dma_rd_data, '0);
         end
      end
   end

   task automatic idle();
      cyc(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   int dma_gnt_cnt;

   initial begin
      for (int i = 0; i < 512; i++) begin
         env_mem[i] = 32'h5A000000 ^ (i * 32'h00010203);
         ref_mem[i] = 32'h5A000000 ^ (i * 32'h00010203);
      end
      mem_rd_data = '0;
      streak = 0; pend = 0;
      reset_n = 1'b0;
      core_rd = 0; core_wr = 0; core_addr = '0; core_wr_data = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wr_data = '0;
      @(posedge clk); #1;

      // Outputs held at 0 while in reset even with active requests.
      cyc(1, 0, 9'h010, 32'h1, 1, 1, 9'h011, 32'h2);
      cyc(1, 1, 9'h012, 32'h3, 1, 0, 9'h013, 32'h4);
      reset_n = 1'b1;
      idle();

      // Core-only read of 0xDEADBEEF at 0x010.
      cyc(0, 1, 9'h010, 32'hDEADBEEF, 0, 0, '0, '0);
      cyc(1, 0, 9'h010, 32'h0, 0, 0, '0, '0);
      idle();

      // DMA write then read of 0x1FF.
      cyc(0, 0, '0, '0, 1, 1, 9'h1FF, 32'h12345678);
      cyc(0, 0, '0, '0, 1, 0, 9'h1FF, 32'h0);
      idle();

      // Starvation: both request continuously; DMA wins every 5th cycle.
      dma_gnt_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1, 0, 9'h030, '0, 1, 0, 9'h031, '0);
      end
      idle();

      // Alternating owners at full rate.
      cyc(1, 0, 9'h001, '0, 0, 0, '0, '0);
      cyc(0, 0, '0, '0, 1, 0, 9'h002, '0);
      cyc(1, 0, 9'h002, '0, 0, 0, '0, '0);
      cyc(0, 0, '0, '0, 1, 0, 9'h001, '0);
      idle();

      // Illegal rd+wr treated as a write, then read back.
      cyc(1, 1, 9'h020, 32'hA5A5A5A5, 0, 0, '0, '0);
      cyc(1, 0, 9'h020, '0, 0, 0, '0, '0);
      idle();

      // Reset mid-read: the core read's return must be dropped, and after
      // release the core wins a conflict again with a fresh streak.
      cyc(1, 1, 9'h040, 32'hCAFEF00D, 1, 0, 9'h041, '0);
      cyc(1, 0, 9'h040, '0, 1, 0, 9'h041, '0);
      reset_n = 1'b0;
      cyc(0, 0, '0, '0, 0, 0, '0, '0);
      cyc(1, 0, 9'h040, '0, 1, 0, 9'h041, '0);
      reset_n = 1'b1;
      idle();
      for (int i = 0; i < 6; i++) cyc(1, 0, 9'h040, '0, 1, 0, 9'h041, '0);
      idle();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         logic crd, cwr, dr, dwe;
         logic [ADDR_W-1:0] ca, da;
         crd = ($urandom_range(0, 99) < 50);
         cwr = ($urandom_range(0, 99) < 25);
         dr  = ($urandom_range(0, 99) < 60);
         dwe = ($urandom_range(0, 99) < 40);
         ca  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
         da  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
         reset_n = ($urandom_range(0, 149) != 0);
         cyc(crd, cwr, ca, $urandom, dr, dwe, da, $urandom);
      end
      reset_n = 1'b1;
      idle();
      idle();

      chk("core_ret_q_empty", 32'(exp_core_q.size()), 32'd0);
      chk("dma_ret_q_empty",  32'(exp_dma_q.size()),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard bound on run time in case something stalls the stimulus.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (9-bit word address, 32-bit data) between two requesters: the core's MEM-stage load/store path and a DMA/debug loader.
- Core has default priority. A starvation counter guarantees DMA forward progress, and `core_stall` freezes the pipeline when the core loses.
- Sits between `Datapath` and the data memory. Memory has synchronous read with 1-cycle latency.

Parameters:
- DATA_W, 32, data width of all data buses
- ADDR_W, 9, word address width
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA gets priority (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- core_rd  in  1  core load request
- core_wr  in  1  core store request
- core_addr  in  ADDR_W  core word address
- core_wr_data  in  DATA_W  core store data
- core_stall  out  1  core request not accepted this cycle; core holds request
- core_rvalid  out  1  core read data valid (cycle after accepted load)
- core_rd_data  out  DATA_W  core load data
- dma_req  in  1  DMA request
- dma_we  in  1  DMA write (1) / read (0)
- dma_addr  in  ADDR_W  DMA word address
- dma_wr_data  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rd_data  out  DATA_W  DMA read data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid cycle after mem_rd

Behaviour:
- Core request: `core_req = core_rd | core_wr`. If both are high, the access is treated as a write; no read is issued.
- Grant is combinational from the current requests and the registered state. At most one grant per cycle. `mem_*` follows the granted requester in the same cycle.
- With no grant, `mem_rd = mem_wr = 0`; `mem_addr` and `mem_wr_data` hold 0.
- Priority FSM `pri_q`, states CORE_PRI and DMA_PRI:
  - CORE_PRI: on conflict, core wins and `dma_gnt = 0`.
  - DMA_PRI: on conflict, DMA wins and `core_stall = 1`.
  - Without conflict, the sole requester is always granted in either state.
- Starvation counter `starve_q` (4 bits):
  - Increments each cycle `dma_req` is high and `dma_gnt` is low.
  - Clears on `dma_gnt`, and also when `dma_req` is low.
  - Saturates at STARVE_LIMIT.
- FSM transitions:
  - CORE_PRI -> DMA_PRI when the next value of `starve_q` equals STARVE_LIMIT.
  - DMA_PRI -> CORE_PRI after exactly one DMA grant, or when `dma_req` drops.
- `core_stall = core_req & ~core_granted`. It is never asserted without `core_req`.
- Read return:
  - Registered `ret_owner_q` ∈ {NONE, CORE, DMA} is set when `mem_rd` is issued, else NONE.
  - Next cycle, `rvalid` is pulsed to that owner and `mem_rd_data` is routed to the matching `*_rd_data`.
  - The non-owner `rd_data` is driven 0.
- Back-to-back reads, including alternating owners, run at full rate: one access per cycle, one return per cycle.
- Writes produce no `rvalid`.
- Reset (async assert, sync deassert by the surrounding reset tree):
  - `pri_q = CORE_PRI`, `starve_q = 0`, `ret_owner_q = NONE`.
  - All outputs read 0 while reset is low.
  - A read in flight when reset asserts is dropped: no `rvalid` after release.

Decomposition:
- Package `dmem_arb_pkg`:
  - `owner_e` enum (NONE, CORE, DMA)
  - `pri_e` enum (CORE_PRI, DMA_PRI)
  - default ADDR_W / DATA_W constants
- One sub-module, `dmem_starve_ctr`: the saturating counter plus its limit compare. Inputs are `req`, `gnt`, `limit`; output is `hit_next`.
- The FSM and return routing stay in `dmem_arbiter`.

Test Plan:
- Core-only: `core_rd` at addr 0x010, memory holds 0xDEADBEEF -> `mem_rd` same cycle, `core_rvalid = 1` with `core_rd_data = 0xDEADBEEF` next cycle, `core_stall = 0` throughout.
- DMA-only: DMA write 0x12345678 to 0x1FF, then DMA read 0x1FF -> `dma_gnt` both cycles, `dma_rvalid` with 0x12345678 one cycle after the read grant.
- Starvation: core and DMA both request continuously, STARVE_LIMIT = 4 -> DMA denied 4 cycles, granted on the 5th with `core_stall = 1` for that cycle only, then core resumes; pattern repeats every 5 cycles.
- Alternating reads: core read 0x001 then DMA read 0x002 on consecutive cycles -> `core_rvalid` then `dma_rvalid` on consecutive cycles, data not crossed.
- Illegal `core_rd = core_wr = 1` at 0x020 with data 0xA5A5A5A5 -> `mem_wr = 1`, `mem_rd = 0`, no `core_rvalid`.
- Reset mid-read: assert reset one cycle after a core read grant -> no `core_rvalid` after release, `pri_q = CORE_PRI`, `starve_q = 0`, all outputs 0 during reset.
